mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage pipeline.
- Sequences one memory transaction at a time and drives per-requester stall signals into the hazard/stall logic.
- Kills an in-flight fetch when a control-hazard redirect flushes IF.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 32, data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  IF requests a fetch; held until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_flush  in  1  control-hazard redirect; kills any pending fetch
if_rdata  out  DATA_W  fetched instruction, registered
if_done  out  1  one-cycle pulse: if_rdata valid
if_stall  out  1  IF must hold
d_req  in  1  MEM stage requests access; held until d_done
d_we  in  1  1 = sw, 0 = lw
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered
d_done  out  1  one-cycle pulse: access complete
d_stall  out  1  MEM (and older stages) must hold
m_valid  out  1  request to memory
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_ready  in  1  memory accepts request this cycle
m_rvalid  in  1  memory response (read data or write ack)
m_rdata  in  DATA_W  memory read data

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-low on rst_n.
  - Reset puts state in IDLE and clears owner, kill, m_valid, m_we, m_addr, m_wdata, if_rdata, d_rdata, if_done and d_done to 0.
- States: IDLE, ISSUE, WAIT, DONE. Owner register is I or D.
- IDLE:
  - d_req beats if_req (the older instruction wins).
  - On a grant, latch owner and the address/we/wdata into the m_* registers. Fetches force m_we=0.
  - Move to ISSUE with m_valid=1 from the next cycle.
  - m_rvalid is ignored in IDLE (covers a stale response after reset).
- ISSUE:
  - m_valid, m_we, m_addr and m_wdata stay stable until m_ready=1.
  - On m_ready, clear m_valid and go to WAIT.
- WAIT:
  - On m_rvalid, latch m_rdata into if_rdata (owner I, read) or d_rdata (owner D, lw). A write leaves d_rdata unchanged.
  - Then go to DONE. If owner=I and kill=1, go straight to IDLE and drop the response.
- DONE:
  - Exactly one cycle.
  - if_done = (owner==I) & ~kill & ~if_flush.
  - d_done = (owner==D).
  - Requests are not sampled. Return to IDLE.
- Minimum latency: request seen in IDLE at cycle 0 → m_valid at 1 → (m_ready@1, m_rvalid@2) → done pulse at 3.
- Stalls are combinational:
  - if_stall = if_req & ~if_done.
  - d_stall = d_req & ~d_done.
- Flush:
  - if_flush while owner=I in ISSUE or WAIT sets kill. An ISSUE request is never withdrawn; it completes on the memory side.
  - kill clears on entry to IDLE.
  - if_flush has no effect on owner=D.
- Requester rule: the cycle after a done pulse, a requester deasserts or presents a new request. The arbiter samples it in IDLE.
- Simultaneous if_req, d_req and if_flush in IDLE: D is granted and the flush is ignored (nothing is pending for IF).
- Reset mid-transaction: the next edge returns to IDLE with m_valid=0. No done pulse is generated.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- When defined, adds two outputs:
  - perf_conflict_cnt [31:0]: increments each cycle state==IDLE & if_req & d_req.
  - perf_busy_cnt [31:0]: increments each cycle state!=IDLE.
  - Both counters wrap modulo 2^32 and reset to 0.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single fetch:
  - Stimulus: if_req, if_addr=0x0000_0040; m_ready at first m_valid; m_rvalid next cycle with m_rdata=0x2008_0005.
  - Required: if_done pulse at cycle 3, if_rdata=0x2008_0005, if_stall high for cycles 0–2.
- Contention:
  - Stimulus: if_req and d_req (lw 0x100) asserted together.
  - Required: D is served first with m_addr=0x100 and d_done. IF's m_valid appears only after DONE; if_stall is held throughout.
- Store with memory backpressure:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF; m_ready low for 3 cycles.
  - Required: m_* stable for all 4 m_valid cycles; d_done after m_rvalid; d_rdata unchanged.
- Flush mid-fetch:
  - Stimulus: if_flush pulses during WAIT.
  - Required: the response is consumed, no if_done, if_rdata unchanged. The next if_req (addr 0x80) is granted normally.
- Reset in WAIT:
  - Stimulus: rst_n=0 for one edge, then m_rvalid arrives in IDLE.
  - Required: state IDLE, m_valid=0, no done pulse, outputs at 0.
- MEMARB_PERF_EN:
  - Stimulus: contention test.
  - Required: perf_conflict_cnt=1; perf_busy_cnt=6 (3 busy cycles per transaction).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and load/store (MEM).
// Optional performance counters are compiled in when MEMARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_busy_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              kill_q, kill_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              flush_hit_s;

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        kill_d     = kill_q;
        m_valid_d  = m_valid_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        flush_hit_s = if_flush & (owner_q == OWN_I);
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (d_req) begin
                    owner_d   = OWN_D;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_valid_d = 1'b1;
                    state_d   = S_ISSUE;
                end else if (if_req) begin
                    owner_d   = OWN_I;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = {DATA_W{1'b0}};
                    m_valid_d = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // A flushed fetch still completes on the memory side; kill only hides the result.
                kill_d = kill_q | flush_hit_s;
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                kill_d = kill_q | flush_hit_s;
                if (m_rvalid) begin
                    if (owner_q == OWN_I) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            if_rdata_d = m_rdata;
                            if_done_d  = ~flush_hit_s;
                            state_d    = S_DONE;
                        end
                    end else begin
                        d_rdata_d = m_we_q ? d_rdata_q : m_rdata;
                        d_done_d  = 1'b1;
                        state_d   = S_DONE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                kill_d    = 1'b0;
                m_valid_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_I;
            kill_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= {ADDR_W{1'b0}};
            m_wdata_q  <= {DATA_W{1'b0}};
            if_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q  <= {DATA_W{1'b0}};
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            kill_q     <= kill_d;
            m_valid_q  <= m_valid_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    // A redirect arriving during DONE still suppresses the fetch completion.
    assign if_done  = if_done_q & ~if_flush;
    assign d_done   = d_done_q;
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        perf_conflict_d = perf_conflict_q +
            (((state_q == S_IDLE) && if_req && d_req) ? 32'd1 : 32'd0);
        perf_busy_d = perf_busy_q + ((state_q != S_IDLE) ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_conflict_q <= 32'd0;
            perf_busy_q     <= 32'd0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_busy_q     <= perf_busy_d;
        end
    end

    assign perf_conflict_cnt = perf_conflict_q;
    assign perf_busy_cnt     = perf_busy_q;
`endif

endmodule
